// File: rtl/ldd_arb_decoder.sv
// rtl/ldd_arb_decoder.sv - registered opcode decoder with fixed/round-robin request arbitration and grant hold
module ldd_arb_decoder #(
    parameter int N_REQ    = 4,
    parameter int OP_W     = 3,
    parameter int HOLD_CYC = 2,
    parameter int RR_MODE  = 0,
    localparam int NCLS    = 1 << OP_W,
    localparam int GW      = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_en,
    input  logic             in_inhibit,
    input  logic [N_REQ-1:0] req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NCLS-1:0]  out_cls,
    output logic [N_REQ-1:0] out_grant,
    output logic [GW-1:0]    out_gidx,
    output logic             out_none,
    output logic             out_inhib,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_HOLD, S_OUT} state_t;

    state_t           state_q, state_d;
    logic [NCLS-1:0]  cls_q, cls_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [GW-1:0]    gidx_q, gidx_d;
    logic [GW-1:0]    ptr_q, ptr_d;
    logic             none_q, none_d;
    logic             inhib_q, inhib_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             win_found;
    logic [GW-1:0]    win_idx;

    // Search starts at the RR pointer in round-robin mode, at index 0 otherwise.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (RR_MODE != 0) ? ((int'(ptr_q) + i) % N_REQ) : i;
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = j[GW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        none_d  = none_q;
        inhib_d = inhib_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cls_d   = in_en ? (NCLS'(1) << in_op) : '0;
                    inhib_d = (in_op == '0) && in_inhibit && in_en;
                    grant_d = '0;
                    gidx_d  = '0;
                    none_d  = 1'b0;
                    if ((in_op == '0) && in_en && !in_inhibit) begin
                        state_d = S_ARB;
                    end else begin
                        state_d = S_OUT;
                    end
                end
            end
            S_ARB: begin
                if (!win_found) begin
                    none_d  = 1'b1;
                    state_d = S_OUT;
                end else begin
                    grant_d = N_REQ'(1) << win_idx;
                    gidx_d  = win_idx;
                    if (RR_MODE != 0) begin
                        ptr_d = (win_idx == GW'(N_REQ - 1)) ? '0 : win_idx + GW'(1);
                    end
                    if (HOLD_CYC > 0) begin
                        state_d = S_HOLD;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = S_OUT;
                    end
                end
            end
            S_HOLD: begin
                // Only the winning line can end the hold early; other lines are ignored.
                if ((cnt_q == 8'(HOLD_CYC)) || !(|(req & grant_q))) begin
                    state_d = S_OUT;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    cls_d   = '0;
                    grant_d = '0;
                    gidx_d  = '0;
                    none_d  = 1'b0;
                    inhib_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cls_q   <= '0;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            none_q  <= 1'b0;
            inhib_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            none_q  <= none_d;
            inhib_q <= inhib_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q == S_ARB) || (state_q == S_HOLD);
    assign out_cls   = cls_q;
    assign out_grant = grant_q;
    assign out_gidx  = gidx_q;
    assign out_none  = none_q;
    assign out_inhib = inhib_q;

endmodule
